// File: rtl/serial_mod_pkg.sv
// ---------------------------------------------------------------------------
// serial_mod_pkg
// Shared definitions for the serial remainder engine.
//   state_t  : frame FSM encoding (ST_IDLE = no frame open, ST_ACCUM = frame open)
//   MODE_LSB : bit order selector value for LSB-first frames
//   MODE_MSB : bit order selector value for MSB-first frames
// ---------------------------------------------------------------------------
package serial_mod_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/mod_step.sv
// ---------------------------------------------------------------------------
// mod_step
// Combinational modular adder: y = (a + b + cin) mod MOD.
// Operands must satisfy a, b < MOD, so the raw sum is below 2*MOD and a
// single conditional subtract is enough (no divider).
// Ports:
//   a, b  in  W   operands, each already reduced mod MOD
//   cin   in  1   carry-in (the serial data bit in MSB-first mode)
//   y     out W   reduced sum
// ---------------------------------------------------------------------------
module mod_step
    import serial_mod_pkg::*;
#(
    parameter int MOD = 5,
    parameter int W   = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] y
);

    // One extra bit so the sum and MOD itself (e.g. 2^16 with W=16) fit.
    localparam logic [W:0] MOD_V = (W+1)'(MOD);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        y   = (sum >= MOD_V) ? W'(sum - MOD_V) : sum[W-1:0];
    end

endmodule

// File: rtl/serial_mod_n.sv
// ---------------------------------------------------------------------------
// serial_mod_n
// Streaming remainder engine. Consumes a framed serial bitstream (one bit per
// accepted beat) and keeps a registered running value mod MOD.
//
// Optional feature macro: SERIAL_MOD_CNT_EN
//   defined   -> bit_cnt port and saturating per-frame bit counter present
//   undefined -> no bit_cnt port, no counter; everything else identical
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      beat qualifier for in_bit/in_sof/in_eof
//   in_bit     in   1      serial data bit
//   in_sof     in   1      first bit of frame
//   in_eof     in   1      last bit of frame
//   msb_first  in   1      bit order, sampled on the SOF beat only
//   out_rem    out  REM_W  running remainder register
//   out_valid  out  1      one-cycle pulse: out_rem holds the final remainder
//   busy       out  1      high while a frame is open
//   bit_cnt    out  CNT_W  accepted bits in frame (SERIAL_MOD_CNT_EN only)
//   fsm_state  out  1      frame FSM state, for observation
//
// Handshake: there is no ready; the engine accepts every beat. A beat is
// accepted when in_valid is high and either in_sof is high or a frame is
// open. in_bit/in_sof/in_eof are ignored whenever in_valid is low, and beats
// without in_sof while no frame is open are dropped.
// ---------------------------------------------------------------------------
module serial_mod_n
    import serial_mod_pkg::*;
#(
    parameter int MOD   = 5,
    parameter int REM_W = $clog2(MOD),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic             msb_first,
    output logic [REM_W-1:0] out_rem,
    output logic             out_valid,
    output logic             busy,
`ifdef SERIAL_MOD_CNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output state_t           fsm_state
);

    if (MOD < 2 || MOD > 65536 || REM_W < 1 || REM_W < $clog2(MOD) || CNT_W < 1) begin : g_bad_params
        $error("serial_mod_n: illegal parameter combination");
    end

    state_t           state_q;
    state_t           state_d;
    logic             accepted;

    logic             mode_q;
    logic             mode_eff;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] weight_q;
    logic [REM_W-1:0] rem_base;
    logic [REM_W-1:0] weight_base;
    logic [REM_W-1:0] step_b;
    logic             step_cin;
    logic [REM_W-1:0] rem_next;
    logic [REM_W-1:0] weight_next;
    logic             valid_q;

    // -------------------------------------------------------------------
    // Frame FSM: state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state and outputs. An accepted EOF beat always closes
    // the frame (this also covers 1-bit sof&eof frames); any other accepted
    // beat, including an aborting SOF, leaves a frame open.
    always_comb begin
        accepted  = in_valid & (in_sof | (state_q == ST_ACCUM));
        state_d   = state_q;
        busy      = (state_q == ST_ACCUM);
        fsm_state = state_q;
        if (accepted) begin
            state_d = in_eof ? ST_IDLE : ST_ACCUM;
        end
    end

    // -------------------------------------------------------------------
    // Datapath operand selection. A SOF beat starts from rem=0, weight=1 and
    // the freshly sampled bit order, then applies its own bit in the same cycle.
    //   MSB-first: rem' = rem + rem + bit
    //   LSB-first: rem' = rem + (bit ? weight : 0)
    // -------------------------------------------------------------------
    always_comb begin
        rem_base    = in_sof ? '0 : rem_q;
        weight_base = in_sof ? REM_W'(1) : weight_q;
        mode_eff    = in_sof ? msb_first : mode_q;
        step_b      = '0;
        step_cin    = 1'b0;
        if (mode_eff == MODE_MSB) begin
            step_b   = rem_base;
            step_cin = in_bit;
        end else begin
            step_b   = in_bit ? weight_base : '0;
            step_cin = 1'b0;
        end
    end

    mod_step #(.MOD(MOD), .W(REM_W)) u_rem_step (
        .a   (rem_base),
        .b   (step_b),
        .cin (step_cin),
        .y   (rem_next)
    );

    // Weight doubling only matters in LSB-first mode; in MSB-first mode it
    // runs along unused and is reseeded on the next SOF.
    mod_step #(.MOD(MOD), .W(REM_W)) u_weight_step (
        .a   (weight_base),
        .b   (weight_base),
        .cin (1'b0),
        .y   (weight_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q    <= '0;
            weight_q <= REM_W'(1);
            mode_q   <= MODE_LSB;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= accepted & in_eof;
            if (accepted) begin
                rem_q    <= rem_next;
                weight_q <= weight_next;
                mode_q   <= mode_eff;
            end
        end
    end

    assign out_rem   = rem_q;
    assign out_valid = valid_q;

`ifdef SERIAL_MOD_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Counts accepted bits in the current frame; restarts at 1 on SOF,
    // saturates, and holds after EOF until the next SOF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accepted) begin
            if (in_sof) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_serial_mod_n.sv
// ---------------------------------------------------------------------------
// tb_serial_mod_n
// Three engines (MOD = 5, 7, 12) share one input stream. A frame-level
// reference keeps the accepted bits of the open frame and recomputes the
// remainder from the integer value of those bits. Optional counter checks
// follow SERIAL_MOD_CNT_EN.
// ---------------------------------------------------------------------------
module tb_serial_mod_n;
    import serial_mod_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic in_valid  = 1'b0;
    logic in_bit    = 1'b0;
    logic in_sof    = 1'b0;
    logic in_eof    = 1'b0;
    logic msb_first = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] rem5, rem7;
    logic [3:0] rem12;
    logic       ov5, ov7, ov12;
    logic       busy5, busy7, busy12;
    state_t     st5, st7, st12;
`ifdef SERIAL_MOD_CNT_EN
    logic [2:0] cnt5, cnt7, cnt12;
`endif

    serial_mod_n #(.MOD(5), .CNT_W(3)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_eof(in_eof), .msb_first(msb_first),
        .out_rem(rem5), .out_valid(ov5), .busy(busy5),
`ifdef SERIAL_MOD_CNT_EN
        .bit_cnt(cnt5),
`endif
        .fsm_state(st5)
    );

    serial_mod_n #(.MOD(7), .CNT_W(3)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_eof(in_eof), .msb_first(msb_first),
        .out_rem(rem7), .out_valid(ov7), .busy(busy7),
`ifdef SERIAL_MOD_CNT_EN
        .bit_cnt(cnt7),
`endif
        .fsm_state(st7)
    );

    serial_mod_n #(.MOD(12), .CNT_W(3)) u_dut12 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_eof(in_eof), .msb_first(msb_first),
        .out_rem(rem12), .out_valid(ov12), .busy(busy12),
`ifdef SERIAL_MOD_CNT_EN
        .bit_cnt(cnt12),
`endif
        .fsm_state(st12)
    );

    // ------------------------------------------------------------------
    // Reference model: frame contents as a bit list
    // ------------------------------------------------------------------
    bit          m_open;
    bit          m_mode;
    bit          m_bits[64];
    int          m_n;
    bit          m_ov;
    int          m_cnt;
    logic [31:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic int model_rem(input int m);
        longint unsigned val = 0;
        for (int i = 0; i < m_n; i++) begin
            if (m_mode) val = (val << 1) | 64'(m_bits[i]);
            else        val = val | (64'(m_bits[i]) << i);
        end
        return int'(val % 64'(m));
    endfunction

    task automatic model_reset();
        m_open = 1'b0;
        m_mode = 1'b0;
        m_n    = 0;
        m_ov   = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic model_update(input logic v, input logic b, input logic sof,
                                input logic eof, input logic msb);
        m_ov = 1'b0;
        if (v && (sof || m_open)) begin
            if (sof) begin
                m_n    = 0;
                m_mode = msb;
                m_cnt  = 0;
            end
            if (m_n < 64) begin
                m_bits[m_n] = b;
                m_n++;
            end
            if (m_cnt < 7) m_cnt++;
            m_open = !eof;
            if (eof) begin
                m_ov = 1'b1;
                exp_q.push_back(32'(model_rem(5)));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / checks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int exp_st;
        exp_st = m_open ? int'(ST_ACCUM) : int'(ST_IDLE);
        chk("rem_mod5",   int'(rem5),  model_rem(5));
        chk("rem_mod7",   int'(rem7),  model_rem(7));
        chk("rem_mod12",  int'(rem12), model_rem(12));
        chk("valid_mod5", int'(ov5),   int'(m_ov));
        chk("valid_mod7", int'(ov7),   int'(m_ov));
        chk("valid_mod12",int'(ov12),  int'(m_ov));
        chk("busy_mod5",  int'(busy5), int'(m_open));
        chk("busy_mod12", int'(busy12),int'(m_open));
        chk("state_mod7", int'(st7),   exp_st);
`ifdef SERIAL_MOD_CNT_EN
        chk("cnt_mod5",   int'(cnt5),  m_cnt);
        chk("cnt_mod12",  int'(cnt12), m_cnt);
`endif
        if (ov5) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_pulse: got out_valid=1 expected no pending result (t=%0t)", $time);
            end else begin
                chk("sb_final_rem5", int'(rem5), int'(exp_q.pop_front()));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic b, input logic sof,
                        input logic eof, input logic msb);
        in_valid  = v;
        in_bit    = b;
        in_sof    = sof;
        in_eof    = eof;
        msb_first = msb;
        @(posedge clk);
        #1;
        model_update(v, b, sof, eof, msb);
        check_all();
    endtask

    // bits[n-1] is sent first.
    task automatic send_frame(input logic [63:0] bits, input int n,
                              input logic msb, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1)
                step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step(1'b1, bits[n-1-i], i == 0, i == n - 1, msb);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic v, b, sof, eof, msb;
        int   rem5, rem7;
        logic ov, busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic b, input logic sof, input logic eof,
                       input logic msb, input int r5, input int r7,
                       input logic ov, input logic bz);
        vec_t t;
        t.v = v; t.b = b; t.sof = sof; t.eof = eof; t.msb = msb;
        t.rem5 = r5; t.rem7 = r7; t.ov = ov; t.busy = bz;
        vecs.push_back(t);
    endtask

    initial begin
        // LSB-first 1,1,0,1,1 = 27
        add(1,1,1,0,0, 1,1, 0,1);
        add(1,1,0,0,0, 3,3, 0,1);
        add(1,0,0,0,0, 3,3, 0,1);
        add(1,1,0,0,0, 1,4, 0,1);
        add(1,1,0,1,0, 2,6, 1,0);
        add(0,0,0,0,0, 2,6, 0,0);
        add(1,1,0,0,1, 2,6, 0,0);   // no SOF while idle: ignored
        // MSB-first 11111 = 31, mode changes after SOF must not matter
        add(1,1,1,0,1, 1,1, 0,1);
        add(1,1,0,0,0, 3,3, 0,1);
        add(1,1,0,0,0, 2,0, 0,1);
        add(0,1,0,0,0, 2,0, 0,1);   // gap
        add(1,1,0,0,0, 0,1, 0,1);
        add(1,1,0,1,0, 1,3, 1,0);
        // LSB-first 11111 = 31
        add(1,1,1,0,0, 1,1, 0,1);
        add(1,1,0,0,1, 3,3, 0,1);
        add(1,1,0,0,1, 2,0, 0,1);
        add(1,1,0,0,1, 0,1, 0,1);
        add(1,1,0,1,1, 1,3, 1,0);
        // MSB-first 101101 = 45
        add(1,1,1,0,1, 1,1, 0,1);
        add(1,0,0,0,0, 2,2, 0,1);
        add(1,1,0,0,0, 0,5, 0,1);
        add(1,1,0,0,0, 1,4, 0,1);
        add(1,0,0,0,0, 2,1, 0,1);
        add(1,1,0,1,0, 0,3, 1,0);
        // single-bit frames
        add(1,1,1,1,0, 1,1, 1,0);
        add(0,0,0,0,0, 1,1, 0,0);
        add(1,0,1,1,1, 0,0, 1,0);
        // abort: SOF after 3 bits, new frame MSB 1,0 = 2
        add(1,1,1,0,1, 1,1, 0,1);
        add(1,1,0,0,0, 3,3, 0,1);
        add(1,1,0,0,0, 2,0, 0,1);
        add(1,1,1,0,1, 1,1, 0,1);
        add(1,0,0,1,0, 2,2, 1,0);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        #12;
        check_all();                               // reset values
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].sof, vecs[i].eof, vecs[i].msb);
            chk("tbl_rem5",  int'(rem5),  vecs[i].rem5);
            chk("tbl_rem7",  int'(rem7),  vecs[i].rem7);
            chk("tbl_valid", int'(ov5),   int'(vecs[i].ov));
            chk("tbl_busy",  int'(busy7), int'(vecs[i].busy));
        end

        // 1101011010: MSB-first 858, LSB-first 363, with random gaps
        send_frame(64'b1101011010, 10, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("msb858_mod5",  int'(rem5),  3);
        chk("msb858_mod7",  int'(rem7),  4);
        chk("msb858_mod12", int'(rem12), 6);
        send_frame(64'b1101011010, 10, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb363_mod5",  int'(rem5),  3);
        chk("lsb363_mod7",  int'(rem7),  6);
        chk("lsb363_mod12", int'(rem12), 3);

        // asynchronous reset in the middle of a frame
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rem5", int'(rem5),  0);
        chk("async_rst_busy", int'(busy5), 0);
        check_all();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

`ifdef SERIAL_MOD_CNT_EN
        send_frame(64'b1011001110, 10, 1'b1, 1'b0);
        chk("cnt_saturated", int'(cnt5), 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cnt_hold", int'(cnt5), 7);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("cnt_restart", int'(cnt5), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            logic v, b, sof, eof, msb;
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            msb = 1'($urandom_range(0, 1));
            sof = m_open ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
            eof = (m_n >= 50) ? 1'b1 : ($urandom_range(0, 11) == 0);
            step(v, b, sof, eof, msb);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
